// File: rtl/uart_pkg.sv
// Shared types for the UART receive-side packet logic: frame FSM states,
// error cause codes and the default frame sync marker.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CSUM    = 3'd3,
    S_DRAIN   = 3'd4
  } frame_state_t;

  typedef enum logic [1:0] {
    ERR_BAD_LEN = 2'd0,
    ERR_CSUM    = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_OVERRUN = 2'd3
  } frame_err_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_timeout_cnt.sv
// Inter-byte watchdog: counts s_tick while enabled, clears on clr, and strobes
// expired on the tick that would take the count past TIMEOUT_TICKS-1.
module uart_timeout_cnt #(
  parameter int TIMEOUT_TICKS = 480
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic s_tick,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_TICKS - 1);

  logic [CNT_W-1:0] cnt;

  // A byte arriving on the same cycle as the final tick cancels the expiry.
  assign expired = en && !clr && s_tick && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || clr || expired) begin
      cnt <= '0;
    end else if (s_tick) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame hunter behind the UART receiver: sync, length, payload (and checksum
// when UART_RX_FRAME_CSUM_EN is defined), then releases the buffered payload.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE     = DEFAULT_SYNC_BYTE,
  parameter int         MAX_LEN       = 16,
  parameter int         TIMEOUT_TICKS = 480
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_tick,
  input  logic [7:0]   rx_data,
  input  logic         rx_done,
  output logic [7:0]   pkt_data,
  output logic         pkt_valid,
  input  logic         pkt_ready,
  output logic         pkt_last,
  output logic         err_valid,
  output logic [1:0]   err_code,
  output logic         busy,
  output frame_state_t state_dbg
);

  localparam int         PTR_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  frame_state_t state;
  logic [7:0]   len;
  logic [7:0]   wr_ptr;
  logic [7:0]   rd_ptr;
  logic [7:0]   rd_next;
`ifdef UART_RX_FRAME_CSUM_EN
  logic [7:0]   sum;
`endif
  logic [7:0]   buf_mem [MAX_LEN];
  logic         tmo_en;
  logic         tmo_expired;

  assign tmo_en    = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM);
  assign rd_next   = rd_ptr + 8'd1;
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  uart_timeout_cnt #(.TIMEOUT_TICKS(TIMEOUT_TICKS)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (tmo_en),
    .clr     (rx_done),
    .s_tick  (s_tick),
    .expired (tmo_expired)
  );

  // Payload storage is deliberately not reset; errors just abandon it.
  always_ff @(posedge clk) begin
    if (state == S_PAYLOAD && rx_done) begin
      buf_mem[wr_ptr[PTR_W-1:0]] <= rx_data;
    end
  end

  // Output stream: a byte moves on any cycle with pkt_valid && pkt_ready;
  // while pkt_valid is high and pkt_ready low, pkt_data and pkt_last hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      len       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
`ifdef UART_RX_FRAME_CSUM_EN
      sum       <= '0;
`endif
      pkt_data  <= '0;
      pkt_valid <= 1'b0;
      pkt_last  <= 1'b0;
      err_valid <= 1'b0;
      err_code  <= '0;
    end else begin
      err_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_done && rx_data == SYNC_BYTE) state <= S_LEN;
        end
        S_LEN: begin
          if (rx_done) begin
            len <= rx_data;
            if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
              err_valid <= 1'b1;
              err_code  <= ERR_BAD_LEN;
              state     <= S_IDLE;
            end else begin
              wr_ptr <= '0;
`ifdef UART_RX_FRAME_CSUM_EN
              sum    <= rx_data;
`endif
              state  <= S_PAYLOAD;
            end
          end else if (tmo_expired) begin
            err_valid <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= S_IDLE;
          end
        end
        S_PAYLOAD: begin
          if (rx_done) begin
            wr_ptr <= wr_ptr + 8'd1;
`ifdef UART_RX_FRAME_CSUM_EN
            sum    <= sum + rx_data;
            if (wr_ptr == len - 8'd1) state <= S_CSUM;
`else
            if (wr_ptr == len - 8'd1) begin
              // The final byte lands in the buffer this same edge, so a
              // one-byte frame forwards it straight to the output.
              rd_ptr    <= '0;
              pkt_data  <= (wr_ptr == 8'd0) ? rx_data : buf_mem[0];
              pkt_valid <= 1'b1;
              pkt_last  <= (len == 8'd1);
              state     <= S_DRAIN;
            end
`endif
          end else if (tmo_expired) begin
            err_valid <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= S_IDLE;
          end
        end
`ifdef UART_RX_FRAME_CSUM_EN
        S_CSUM: begin
          if (rx_done) begin
            if (rx_data == sum) begin
              rd_ptr    <= '0;
              pkt_data  <= buf_mem[0];
              pkt_valid <= 1'b1;
              pkt_last  <= (len == 8'd1);
              state     <= S_DRAIN;
            end else begin
              err_valid <= 1'b1;
              err_code  <= ERR_CSUM;
              state     <= S_IDLE;
            end
          end else if (tmo_expired) begin
            err_valid <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= S_IDLE;
          end
        end
`endif
        S_DRAIN: begin
          if (rx_done) begin
            err_valid <= 1'b1;
            err_code  <= ERR_OVERRUN;
          end
          if (pkt_ready) begin
            if (pkt_last) begin
              pkt_valid <= 1'b0;
              pkt_last  <= 1'b0;
              state     <= S_IDLE;
            end else begin
              rd_ptr   <= rd_next;
              pkt_data <= buf_mem[rd_next[PTR_W-1:0]];
              pkt_last <= (rd_next == len - 8'd1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
